// File: rtl/serial_subtractor_i12_o7_if.sv
// Handshake bundle for the bit-serial subtractor.
//   in_valid/in_ready : operand bundle transfer (pi = {B, A})
//   out_valid/out_ready : result transfer (po = {borrow, diff})
// master: the producer of operands and consumer of results.
// slave : the subtractor itself.
interface serial_subtractor_i12_o7_if #(
    parameter int WIDTH = 6
);
    logic               in_valid;
    logic               in_ready;
    logic [2*WIDTH-1:0] pi;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH:0]     po;

    modport master (
        output in_valid,
        output pi,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  po
    );

    modport slave (
        input  in_valid,
        input  pi,
        input  out_ready,
        output in_ready,
        output out_valid,
        output po
    );
endinterface

// File: rtl/serial_subtractor_i12_o7.sv
// Bit-serial unsigned subtractor. Captures A and B from one bundle, then
// resolves the borrow chain LSB-first, one bit per clock, and presents the
// (WIDTH+1)-bit two's-complement difference A-B.
// Ports:
//   clk  : single clock, rising edge
//   rst  : synchronous, active-high reset
//   bus  : slave side of the handshake bundle
//          pi[WIDTH-1:0] = A, pi[2*WIDTH-1:WIDTH] = B (unsigned)
//          po = {borrow, diff} = (A-B) mod 2^(WIDTH+1)
module serial_subtractor_i12_o7 #(
    parameter int WIDTH = 6
) (
    input  logic                          clk,
    input  logic                          rst,
    serial_subtractor_i12_o7_if.slave     bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_reg, state_next;
    logic [WIDTH-1:0] a_reg, a_next;
    logic [WIDTH-1:0] b_reg, b_next;
    logic [WIDTH-1:0] diff_reg, diff_next;
    logic             borrow_reg, borrow_next;
    logic [CW-1:0]    cnt_reg, cnt_next;
    logic [WIDTH:0]   po_reg, po_next;

    // One-hot select of the bit position currently being resolved.
    logic [WIDTH-1:0] bit_sel;
    logic             a_bit;
    logic             b_bit;
    logic             d_bit;
    logic             borrow_bit;
    logic [WIDTH-1:0] diff_run;

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign bit_sel[gi]  = (cnt_reg == CW'(gi));
            // Only the selected position takes the new difference bit.
            assign diff_run[gi] = bit_sel[gi] ? d_bit : diff_reg[gi];
        end
    endgenerate

    assign a_bit      = |(a_reg & bit_sel);
    assign b_bit      = |(b_reg & bit_sel);
    assign d_bit      = a_bit ^ b_bit ^ borrow_reg;
    assign borrow_bit = (~a_bit & b_bit) | (~(a_bit ^ b_bit) & borrow_reg);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg  <= IDLE;
            a_reg      <= '0;
            b_reg      <= '0;
            diff_reg   <= '0;
            borrow_reg <= 1'b0;
            cnt_reg    <= '0;
            po_reg     <= '0;
        end else begin
            state_reg  <= state_next;
            a_reg      <= a_next;
            b_reg      <= b_next;
            diff_reg   <= diff_next;
            borrow_reg <= borrow_next;
            cnt_reg    <= cnt_next;
            po_reg     <= po_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        a_next      = a_reg;
        b_next      = b_reg;
        diff_next   = diff_reg;
        borrow_next = borrow_reg;
        cnt_next    = cnt_reg;
        po_next     = po_reg;
        case (state_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    a_next      = bus.pi[WIDTH-1:0];
                    b_next      = bus.pi[2*WIDTH-1:WIDTH];
                    borrow_next = 1'b0;
                    cnt_next    = '0;
                    state_next  = RUN;
                end
            end
            RUN: begin
                diff_next   = diff_run;
                borrow_next = borrow_bit;
                cnt_next    = cnt_reg + CW'(1);
                if (cnt_reg == LAST_BIT) begin
                    // po is loaded only on DONE entry so it holds its last
                    // completed value during IDLE and RUN.
                    po_next    = {borrow_bit, diff_run};
                    state_next = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.out_valid = (state_reg == DONE);
    assign bus.po        = po_reg;
endmodule

// File: tb/tb_serial_subtractor_i12_o7.sv
// Scoreboard bench for serial_subtractor_i12_o7: stimulus pushes expected
// results at each accepted bundle; a monitor pops and compares at every
// output transfer.
module tb_serial_subtractor_i12_o7;
    localparam int W = 6;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    serial_subtractor_i12_o7_if #(.WIDTH(W)) bus ();

    serial_subtractor_i12_o7 #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    logic [W:0] exp_q[$];
    int pass_cnt  = 0;
    int total_cnt = 0;
    int accepted  = 0;
    int produced  = 0;
    bit rand_mode = 1'b0;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endfunction

    // Monitor: an output transfer happens at the next rising edge whenever
    // out_valid & out_ready are seen here.
    logic [W:0] mon_exp;
    always @(negedge clk) begin
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            produced++;
            if (exp_q.size() == 0) begin
                total_cnt++;
                $display("FAIL unexpected_output: got po=%0h expected no output", bus.po);
            end else begin
                mon_exp = exp_q.pop_front();
                $display("txn %0d: po=%02h exp=%02h", produced, bus.po, mon_exp);
                check("po", 32'(bus.po), 32'(mon_exp));
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Present one bundle and hold it until accepted; called at posedge+1.
    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W:0] e, input int stall);
        int guard;
        guard = 0;
        for (int i = 0; i < stall; i++) tick();
        while (bus.in_ready !== 1'b1 && guard < 200) begin
            tick();
            guard++;
        end
        if (bus.in_ready !== 1'b1) begin
            check("in_ready_timeout", 32'(bus.in_ready), 32'd1);
            return;
        end
        bus.pi       = {b, a};
        bus.in_valid = 1'b1;
        @(posedge clk);
        exp_q.push_back(e);
        accepted++;
        #1;
        bus.in_valid = 1'b0;
        bus.pi       = 12'($urandom);
        if (rand_mode) bus.out_ready = 1'($urandom_range(0, 1));
    endtask

    // Counts edges from the accepting edge (inclusive) to out_valid rising.
    task automatic measure_latency(input string name);
        int lat;
        lat = 1;
        while (bus.out_valid !== 1'b1 && lat < 50) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check(name, 32'(lat), 32'(W + 1));
    endtask

    initial begin
        logic [W:0] e;
        int guard;

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.pi        = '0;
        rst           = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 32'(bus.in_ready), 32'd1);
        check("reset_out_valid", 32'(bus.out_valid), 32'd0);
        check("reset_po", 32'(bus.po), 32'd0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Directed vectors with hand-computed results.
        issue(6'd5, 6'd3, 7'h02, 0);   measure_latency("lat_5_3");
        issue(6'd3, 6'd5, 7'h7E, 0);   measure_latency("lat_3_5");
        issue(6'd0, 6'd63, 7'h41, 0);  measure_latency("lat_0_63");
        issue(6'd63, 6'd0, 7'h3F, 0);  measure_latency("lat_63_0");
        issue(6'd42, 6'd42, 7'h00, 0); measure_latency("lat_42_42");

        // Backpressure: 20-7 = 13 held in DONE for 10 cycles.
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        issue(6'd20, 6'd7, 7'h0D, 0);
        measure_latency("lat_bp");
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp_po", 32'(bus.po), 32'h0D);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        check("release_out_valid", 32'(bus.out_valid), 32'd0);
        check("release_in_ready", 32'(bus.in_ready), 32'd1);

        // Reset on the third RUN edge aborts the transaction (never scored).
        bus.pi       = {6'd9, 6'd30};
        bus.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort_in_ready", 32'(bus.in_ready), 32'd1);
        check("abort_out_valid", 32'(bus.out_valid), 32'd0);
        check("abort_po", 32'(bus.po), 32'd0);
        repeat (10) @(posedge clk);
        #1;
        check("abort_no_output", 32'(bus.out_valid), 32'd0);
        issue(6'd30, 6'd9, 7'h15, 0);
        measure_latency("lat_after_abort");
        @(posedge clk);
        #1;

        // Exhaustive sweep with random input gaps and output stalls.
        rand_mode = 1'b1;
        for (int a = 0; a < (1 << W); a++) begin
            for (int b = 0; b < (1 << W); b++) begin
                e = {1'b0, W'(a)} - {1'b0, W'(b)};
                issue(W'(a), W'(b), e, $urandom_range(0, 2));
            end
        end
        rand_mode     = 1'b0;
        bus.out_ready = 1'b1;
        guard = 0;
        while (exp_q.size() != 0 && guard < 100) begin
            @(posedge clk);
            #1;
            guard++;
        end
        check("queue_drained", 32'(exp_q.size()), 32'd0);
        check("txn_count", 32'(produced), 32'(accepted));

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end
endmodule
